add_out_responder: RTL and testbench



---
 rtl/add_out_responder.sv | 147 ++++++++++++++
 tb/tb_add_out_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_out_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : add_out_responder                                               |
// | Purpose  : add_out bus responder: {cout,sum} = a+b+cin via a fixed-latency |
// |            pipeline into a credit-protected, in-order output FIFO.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module add_out_responder #(
  parameter int add_width  = 4,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [add_width-1:0]          a,
  input  logic [add_width-1:0]          b,
  input  logic                          cin,
  output logic [add_width-1:0]          sum,
  output logic                          cout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic [15:0]                   txn_count
);

  localparam int C_RES_W = add_width + 1;
  localparam int C_AW    = $clog2(FIFO_DEPTH);
  localparam int C_OW    = C_AW + 1;
  localparam logic [C_OW-1:0] C_DEPTH = C_OW'(FIFO_DEPTH);

  logic                r_in_ready;
  logic [C_OW-1:0]     r_occ;
  logic [C_OW-1:0]     r_count;
  logic [C_AW-1:0]     r_wr_ptr;
  logic [C_AW-1:0]     r_rd_ptr;
  logic [C_RES_W-1:0]  r_mem [FIFO_DEPTH];
  logic [C_RES_W-1:0]  r_last;
  logic [15:0]         r_txn;

  logic                w_accept;
  logic                w_pop;
  logic                w_push;
  logic [C_RES_W-1:0]  w_result;
  logic [C_RES_W-1:0]  w_push_data;
  logic [C_OW-1:0]     w_occ_next;

  assign w_accept = in_valid && r_in_ready;
  assign w_result = {1'b0, a} + {1'b0, b} + {{add_width{1'b0}}, cin};

  // The FIFO write is the final stage, so LATENCY-1 registers sit in front of it.
  generate
    if (LATENCY == 1) begin : g_direct
      assign w_push      = w_accept;
      assign w_push_data = w_result;
    end else begin : g_pipe
      logic [LATENCY-2:0] r_vld;
      logic [C_RES_W-1:0] r_dat [LATENCY-1];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vld <= '0;
        end else begin
          r_vld[0] <= w_accept;
          for (int i = 1; i < LATENCY - 1; i++) begin
            r_vld[i] <= r_vld[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        r_dat[0] <= w_result;
        for (int i = 1; i < LATENCY - 1; i++) begin
          r_dat[i] <= r_dat[i-1];
        end
      end

      assign w_push      = r_vld[LATENCY-2];
      assign w_push_data = r_dat[LATENCY-2];
    end
  endgenerate

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Credits track FIFO entries plus in-flight pipeline entries together.
  always_comb begin
    w_occ_next = r_occ;
    if (w_accept && !w_pop) begin
      w_occ_next = r_occ + 1'b1;
    end else if (!w_accept && w_pop) begin
      w_occ_next = r_occ - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ      <= '0;
      r_in_ready <= 1'b0;
      r_last     <= '0;
      r_txn      <= '0;
    end else begin
      r_occ      <= w_occ_next;
      r_in_ready <= (w_occ_next < C_DEPTH);
      if (w_pop) begin
        r_last <= r_mem[r_rd_ptr];
        r_txn  <= r_txn + 16'd1;
      end
    end
  end

  // With the FIFO empty the bus keeps showing the most recently consumed result.
  assign {cout, sum} = out_valid ? r_mem[r_rd_ptr] : r_last;
  assign in_ready    = r_in_ready;
  assign occupancy   = r_occ;
  assign txn_count   = r_txn;

endmodule
`default_nettype wire

// File: tb/tb_add_out_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_add_out_responder                                            |
// | Purpose  : Directed self-checking bench for add_out_responder.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_add_out_responder;

  localparam int W     = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic [W-1:0]  sum;
  logic          cout;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    occupancy;
  logic [15:0]   txn_count;

  int n_checks = 0;
  int n_fail   = 0;
  int a_checks = 0;
  int a_fail   = 0;

  always #5 clk = ~clk;

  add_out_responder #(.add_width(W), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy), .txn_count(txn_count)
  );

  // Protocol monitors: stalled output must hold, and no push into a full FIFO.
  logic         pv = 1'b0, pr = 1'b0, prst = 1'b0, pc = 1'b0;
  logic [W-1:0] ps = '0;
  always @(negedge clk) begin
    if (rst && prst && pv && !pr) begin
      a_checks++;
      if (!(out_valid === 1'b1 && sum === ps && cout === pc)) begin
        a_fail++;
        $display("FAIL hold_stable: got v=%b sum=%h cout=%b want v=1 sum=%h cout=%b", out_valid, sum, cout, ps, pc);
      end
    end
    if (rst && dut.w_push) begin
      a_checks++;
      if (dut.r_count == 3'(DEPTH) && !dut.w_pop) begin
        a_fail++;
        $display("FAIL full_write: push with count=%0d and no pop, want count<%0d", dut.r_count, DEPTH);
      end
    end
    pv = out_valid; pr = out_ready; ps = sum; pc = cout; prst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (sum !== 4'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_checks++; if (txn_count !== 16'd0) begin n_fail++; $display("FAIL reset_txn: got %0d want 0", txn_count); end
    rst = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1; in_valid = 1'b1; a = 4'h9; b = 4'h8; cin = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    n_checks++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL basic_occ_inflight: got %0d want 1", occupancy); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_checks++; if (sum !== 4'h2) begin n_fail++; $display("FAIL basic_sum: got %h want 2", sum); end
    n_checks++; if (cout !== 1'b1) begin n_fail++; $display("FAIL basic_cout: got %b want 1", cout); end
    tick();
    n_checks++; if (txn_count !== 16'd1) begin n_fail++; $display("FAIL basic_txn: got %0d want 1", txn_count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b want 0", out_valid); end
    n_checks++; if (sum !== 4'h2) begin n_fail++; $display("FAIL basic_sum_hold: got %h want 2", sum); end
  endtask

  task automatic test_extremes();
    out_ready = 1'b1; in_valid = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b1;
    tick();
    a = 4'h0; b = 4'h0; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++; if ({out_valid, cout, sum} !== 6'b1_1_1111) begin n_fail++; $display("FAIL ext_max: got v=%b cout=%b sum=%h want v=1 cout=1 sum=f", out_valid, cout, sum); end
    tick();
    n_checks++; if ({out_valid, cout, sum} !== 6'b1_0_0000) begin n_fail++; $display("FAIL ext_zero: got v=%b cout=%b sum=%h want v=1 cout=0 sum=0", out_valid, cout, sum); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ext_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int nxt, acc, got, expv;
    logic hs_in, hs_out;
    logic [W-1:0] s;
    out_ready = 1'b0; in_valid = 1'b1; nxt = 1; acc = 0; a = 4'(nxt); b = '0; cin = 1'b0;
    for (int c = 0; c < 10; c++) begin
      hs_in = in_valid && in_ready;
      tick();
      if (hs_in) begin acc++; nxt++; a = 4'(nxt); end
    end
    n_checks++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occupancy: got %0d want 4", occupancy); end
    n_checks++; if ({out_valid, cout, sum} !== 6'b1_0_0001) begin n_fail++; $display("FAIL bp_head: got v=%b cout=%b sum=%h want v=1 cout=0 sum=1", out_valid, cout, sum); end
    out_ready = 1'b1; got = 0; expv = 1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      s = sum;
      tick();
      if (hs_out) begin
        n_checks++; if (s !== 4'(expv)) begin n_fail++; $display("FAIL bp_order: got %h want %h", s, 4'(expv)); end
        expv++; got++;
      end
      if (hs_in) begin
        nxt++;
        if (nxt > 6) in_valid = 1'b0;
        else a = 4'(nxt);
      end
    end
    in_valid = 1'b0;
    n_checks++; if (got !== 6) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 6", got); end
    n_checks++; if (nxt !== 7) begin n_fail++; $display("FAIL bp_ops_accepted: got %0d want 6", nxt - 1); end
  endtask

  task automatic test_throughput();
    int nxt, got, first, last, drops;
    logic hs_in, hs_out;
    logic [W:0] r;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; b = 4'h1; cin = 1'b0; nxt = 0; a = '0;
    got = 0; first = -1; last = -1; drops = 0;
    for (int c = 0; c < 40 && got < 20; c++) begin
      if (in_valid && !in_ready) drops++;
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      r = {cout, sum};
      tick();
      if (hs_out) begin
        n_checks++; if (r !== 5'((got % 16) + 1)) begin n_fail++; $display("FAIL tp_result%0d: got %h want %h", got, r, 5'((got % 16) + 1)); end
        if (first < 0) first = c;
        last = c; got++;
      end
      if (hs_in) begin
        nxt++;
        if (nxt == 20) in_valid = 1'b0;
        else a = 4'(nxt);
      end
    end
    in_valid = 1'b0;
    n_checks++; if (drops !== 0) begin n_fail++; $display("FAIL tp_in_ready_drops: got %0d want 0", drops); end
    n_checks++; if (got !== 20) begin n_fail++; $display("FAIL tp_count: got %0d want 20", got); end
    n_checks++; if (first !== LAT || last !== LAT + 19) begin n_fail++; $display("FAIL tp_timing: got first=%0d last=%0d want %0d,%0d", first, last, LAT, LAT + 19); end
    n_checks++; if (txn_count !== 16'd20) begin n_fail++; $display("FAIL tp_txn: got %0d want 20", txn_count); end
  endtask

  task automatic test_reset_mid();
    int acc, stale;
    logic hs_in;
    out_ready = 1'b0; in_valid = 1'b1; a = 4'h3; b = 4'h4; cin = 1'b0; acc = 0;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      hs_in = in_valid && in_ready;
      tick();
      if (hs_in) acc++;
    end
    in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (occupancy !== 3'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_buffered: got occ=%0d v=%b want occ=3 v=1", occupancy, out_valid); end
    rst = 1'b0;
    #1;
    n_checks++; if ({out_valid, cout, sum} !== 6'b0) begin n_fail++; $display("FAIL rm_outputs: got v=%b cout=%b sum=%h want all 0", out_valid, cout, sum); end
    n_checks++; if (occupancy !== 3'd0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_credits: got occ=%0d rdy=%b want occ=0 rdy=0", occupancy, in_ready); end
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
    n_checks++; if (txn_count !== 16'd0) begin n_fail++; $display("FAIL rm_txn: got %0d want 0", txn_count); end
    out_ready = 1'b1; stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) stale++;
      tick();
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rm_stale: got %0d stale results want 0", stale); end
  endtask

  task automatic test_wrap();
    int acc, pops;
    logic hs_in, hs_out;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; a = 4'h1; b = 4'h2; acc = 0; pops = 0;
    for (int c = 0; c < 70000 && pops < 65537; c++) begin
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      tick();
      if (hs_out) begin
        pops++;
        if (pops == 65536) begin
          n_checks++; if (txn_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 0000", txn_count); end
        end
      end
      if (hs_in) begin
        acc++;
        if (acc == 65537) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (pops !== 65537) begin n_fail++; $display("FAIL wrap_pops: got %0d want 65537", pops); end
    n_checks++; if (txn_count !== 16'h0001) begin n_fail++; $display("FAIL wrap_txn: got %h want 0001", txn_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_wrap();
    tick();
    n_checks += a_checks;
    n_fail   += a_fail;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
